// File: rtl/demux1x2_stream.sv
// 1:2 stream demultiplexer: each word is steered by in_sel to one of two 2-entry FIFOs.
// Optional DEMUX_STATS_EN adds per-channel pop counters cnt1/cnt2.
module demux1x2_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2
`endif
);

    // Index 0 is channel 1 (out1), index 1 is channel 2 (out2).
    logic [WIDTH-1:0] mem   [2][DEPTH];
    logic [1:0]       count [2];
    logic [1:0]       wptr;
    logic [1:0]       rptr;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;

    assign full[0] = (count[0] == 2'd2);
    assign full[1] = (count[1] == 2'd2);

    // Readiness ignores a same-cycle pop, so a full channel never passes a word through.
    assign in_ready = in_sel ? !full[1] : !full[0];

    assign push[0] = in_valid && in_ready && !in_sel;
    assign push[1] = in_valid && in_ready &&  in_sel;
    assign pop[0]  = out1_valid && out1_ready;
    assign pop[1]  = out2_valid && out2_ready;

    assign out1_valid = (count[0] != 2'd0);
    assign out2_valid = (count[1] != 2'd0);
    assign out1_data  = mem[0][rptr[0]];
    assign out2_data  = mem[1][rptr[1]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: buffer entries are reset too, because the outputs read them directly and must be 0 in reset.
            for (int ch = 0; ch < 2; ch++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[ch][i] <= '0;
                end
                count[ch] <= 2'd0;
            end
            wptr <= 2'b00;
            rptr <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values regardless of statement order.
            for (int ch = 0; ch < 2; ch++) begin
                if (push[ch]) begin
                    mem[ch][wptr[ch]] <= in_data;
                    wptr[ch]          <= ~wptr[ch];
                end
                if (pop[ch]) begin
                    rptr[ch] <= ~rptr[ch];
                end
                if (push[ch] && !pop[ch]) begin
                    count[ch] <= count[ch] + 2'd1;
                end else if (pop[ch] && !push[ch]) begin
                    count[ch] <= count[ch] - 2'd1;
                end
            end
        end
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= 16'd0;
            cnt2 <= 16'd0;
        end else begin
            if (pop[0]) cnt1 <= cnt1 + 16'd1;
            if (pop[1]) cnt2 <= cnt2 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Directed bench for demux1x2_stream; define DEMUX_STATS_EN to also exercise cnt1/cnt2.
module tb_demux1x2_stream;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
`ifdef DEMUX_STATS_EN
    logic [15:0] cnt1;
    logic [15:0] cnt2;
`endif

    int vectors;
    int miscompares;

    demux1x2_stream #(.WIDTH(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
`ifdef DEMUX_STATS_EN
        ,
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        #12;
        vectors++;
        if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
            $display("FAIL reset_valid: got out1_valid=%b out2_valid=%b, want 0 0", out1_valid, out2_valid);
            miscompares++;
        end
        vectors++;
        if (out1_data !== 32'h0 || out2_data !== 32'h0) begin
            $display("FAIL reset_data: got out1_data=%h out2_data=%h, want 0 0", out1_data, out2_data);
            miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_ready_sel0: got %b, want 1", in_ready);
            miscompares++;
        end
        in_sel = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_ready_sel1: got %b, want 1", in_ready);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        out1_ready = 1'b1; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA0001;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL single_ready: got %b, want 1", in_ready);
            miscompares++;
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hAAAA0001 || out2_valid !== 1'b0) begin
            $display("FAIL single_out: got v1=%b d1=%h v2=%b, want 1 aaaa0001 0", out1_valid, out1_data, out2_valid);
            miscompares++;
        end
        step();
        vectors++;
        if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
            $display("FAIL single_drained: got v1=%b v2=%b, want 0 0", out1_valid, out2_valid);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        out1_ready = 1'b0; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        in_data = 32'h99;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bp_full_ready: got %b, want 0", in_ready);
            miscompares++;
        end
        step();
        in_sel = 1'b1; in_data = 32'h33;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_other_ready: got %b, want 1", in_ready);
            miscompares++;
        end
        step();
        in_valid = 1'b0; in_sel = 1'b0;
        vectors++;
        if (out2_valid !== 1'b1 || out2_data !== 32'h33) begin
            $display("FAIL bp_ch2: got v2=%b d2=%h, want 1 00000033", out2_valid, out2_data);
            miscompares++;
        end
        vectors++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h11) begin
            $display("FAIL bp_ch1_held: got v1=%b d1=%h, want 1 00000011", out1_valid, out1_data);
            miscompares++;
        end
        out1_ready = 1'b1; out2_ready = 1'b1;
        step();
        vectors++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h22 || out2_valid !== 1'b0) begin
            $display("FAIL bp_drain1: got v1=%b d1=%h v2=%b, want 1 00000022 0", out1_valid, out1_data, out2_valid);
            miscompares++;
        end
        step();
        vectors++;
        if (out1_valid !== 1'b0) begin
            $display("FAIL bp_drain2: got v1=%b, want 0 (rejected word must not appear)", out1_valid);
            miscompares++;
        end
        out1_ready = 1'b0; out2_ready = 1'b0;
    endtask

    task automatic test_simul_push_pop();
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
        step();
        out1_ready = 1'b1; in_data = 32'h44;
        #1;
        vectors++;
        if (out1_data !== 32'h11 || in_ready !== 1'b1) begin
            $display("FAIL simul_pre: got d1=%h ready=%b, want 00000011 1", out1_data, in_ready);
            miscompares++;
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h44) begin
            $display("FAIL simul_next: got v1=%b d1=%h, want 1 00000044", out1_valid, out1_data);
            miscompares++;
        end
        step();
        vectors++;
        if (out1_valid !== 1'b0) begin
            $display("FAIL simul_empty: got v1=%b, want 0", out1_valid);
            miscompares++;
        end
        out1_ready = 1'b0;
    endtask

    task automatic test_interleave();
        out1_ready = 1'b1; out2_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_sel   = ((i % 2) == 0);
            in_data  = i;
            step();
            vectors++;
            if (!in_sel && (out1_valid !== 1'b1 || out1_data !== i || out2_valid !== 1'b0)) begin
                $display("FAIL interleave_w%0d: got v1=%b d1=%h v2=%b, want 1 %h 0", i, out1_valid, out1_data, out2_valid, i);
                miscompares++;
            end else if (in_sel && (out2_valid !== 1'b1 || out2_data !== i || out1_valid !== 1'b0)) begin
                $display("FAIL interleave_w%0d: got v2=%b d2=%h v1=%b, want 1 %h 0", i, out2_valid, out2_data, out1_valid, i);
                miscompares++;
            end
        end
        in_valid = 1'b0; in_sel = 1'b0;
        step();
        vectors++;
        if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin
            $display("FAIL interleave_end: got v1=%b v2=%b, want 0 0", out1_valid, out2_valid);
            miscompares++;
        end
        out1_ready = 1'b0; out2_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55;
        step();
        in_data = 32'h66;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h55) begin
            $display("FAIL areset_pre: got v1=%b d1=%h, want 1 00000055", out1_valid, out1_data);
            miscompares++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out1_valid !== 1'b0 || out1_data !== 32'h0 || in_ready !== 1'b1) begin
            $display("FAIL areset_now: got v1=%b d1=%h ready=%b, want 0 0 1", out1_valid, out1_data, in_ready);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (out1_valid !== 1'b0) begin
            $display("FAIL areset_after: got v1=%b, want 0", out1_valid);
            miscompares++;
        end
    endtask

`ifdef DEMUX_STATS_EN
    task automatic test_stats();
        vectors++;
        if (cnt1 !== 16'h0 || cnt2 !== 16'h0) begin
            $display("FAIL stats_reset: got cnt1=%h cnt2=%h, want 0 0", cnt1, cnt2);
            miscompares++;
        end
        out1_ready = 1'b1; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            in_data = i;
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (cnt1 !== 16'hFFFF) begin
            $display("FAIL stats_pre_wrap: got cnt1=%h, want ffff", cnt1);
            miscompares++;
        end
        step();
        vectors++;
        if (cnt1 !== 16'h0000 || out1_valid !== 1'b0) begin
            $display("FAIL stats_wrap: got cnt1=%h v1=%b, want 0000 0", cnt1, out1_valid);
            miscompares++;
        end
        out2_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h77;
        step();
        in_valid = 1'b0;
        step();
        vectors++;
        if (cnt2 !== 16'h0001 || cnt1 !== 16'h0000) begin
            $display("FAIL stats_ch2: got cnt1=%h cnt2=%h, want 0000 0001", cnt1, cnt2);
            miscompares++;
        end
        out1_ready = 1'b0; out2_ready = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_simul_push_pop();
        test_interleave();
        test_async_reset();
`ifdef DEMUX_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
